// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, PC-select encodings, sequencer
// state encoding and architectural register numbers.
package cpu_pkg;

  localparam int unsigned PC_W           = 32;  // PC and operand width
  localparam int unsigned IMEM_AW        = 12;  // instruction-memory address width
  localparam int unsigned TGT_W          = 27;  // j/jal/bex target field width
  localparam int unsigned MD_TIMEOUT_DEF = 40;  // default multdiv wait limit

  // pcmux_x encodings from control for the X-stage instruction
  localparam logic [1:0] PCMUX_PC1 = 2'b00;
  localparam logic [1:0] PCMUX_BR  = 2'b01;
  localparam logic [1:0] PCMUX_TGT = 2'b10;
  localparam logic [1:0] PCMUX_RD  = 2'b11;

  localparam int unsigned RSTATUS_REG = 30;
  localparam int unsigned RA_REG      = 31;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the pipeline control/X stage and the PC sequencer.
// slave  : sequencer side (takes X-stage flags, drives PC/flush/stall/multdiv)
// master : pipeline side
interface pc_sequencer_if;
  import cpu_pkg::*;

  logic [1:0]         pcmux_x;
  logic               bne_x;
  logic               blt_x;
  logic               bex_x;
  logic               neq_x;
  logic               lt_x;
  logic               rstatus_nz;
  logic [PC_W-1:0]    pc_x;
  logic [PC_W-1:0]    sei_x;
  logic [TGT_W-1:0]   target_x;
  logic [PC_W-1:0]    rd_val_x;
  logic               hazard_stall;
  logic               md_op_x;
  logic               md_ready;

  logic [PC_W-1:0]    pc;
  logic [IMEM_AW-1:0] imem_addr;
  logic [PC_W-1:0]    pc_plus1;
  logic               flush_fd;
  logic               flush_dx;
  logic               stall_fd;
  logic               stall_pipe;
  logic               md_start;
  logic               md_timeout;

  modport slave (
    input  pcmux_x, bne_x, blt_x, bex_x, neq_x, lt_x, rstatus_nz,
           pc_x, sei_x, target_x, rd_val_x, hazard_stall, md_op_x, md_ready,
    output pc, imem_addr, pc_plus1, flush_fd, flush_dx, stall_fd,
           stall_pipe, md_start, md_timeout
  );

  modport master (
    output pcmux_x, bne_x, blt_x, bex_x, neq_x, lt_x, rstatus_nz,
           pc_x, sei_x, target_x, rd_val_x, hazard_stall, md_op_x, md_ready,
    input  pc, imem_addr, pc_plus1, flush_fd, flush_dx, stall_fd,
           stall_pipe, md_start, md_timeout
  );

endinterface

// File: rtl/pc_sequencer_next_pc_sel.sv
// Combinational redirect decision and redirect-target mux for the X stage.
// Inputs : pcmux_x, branch/bex flags, compare results, pc_x, sei_x,
//          target_x, rd_val_x
// Outputs: redirect_c (fetch must be redirected), target_c (redirect PC)
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [1:0]       pcmux_x,
  input  logic             bne_x,
  input  logic             blt_x,
  input  logic             bex_x,
  input  logic             neq_x,
  input  logic             lt_x,
  input  logic             rstatus_nz,
  input  logic [PC_W-1:0]  pc_x,
  input  logic [PC_W-1:0]  sei_x,
  input  logic [TGT_W-1:0] target_x,
  input  logic [PC_W-1:0]  rd_val_x,
  output logic             redirect_c,
  output logic [PC_W-1:0]  target_c
);

  logic br_taken;
  logic bex_taken;

  // Branch direction comes only from the bne/blt flags; pcmux_x[0] is ignored.
  always_comb begin
    br_taken   = (bne_x & neq_x) | (blt_x & lt_x);
    bex_taken  = bex_x & rstatus_nz;
    redirect_c = br_taken | bex_taken | pcmux_x[1];
    target_c   = pc_x + PC_W'(1) + sei_x;
    if (bex_taken || (pcmux_x == PCMUX_TGT)) begin
      target_c = {{(PC_W - TGT_W){1'b0}}, target_x};
    end else if (pcmux_x == PCMUX_RD) begin
      target_c = rd_val_x;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, fetch redirect, hazard freeze and multdiv start/ready handshake.
// Ports: clock, reset_n (synchronous, active-low), bus (pc_sequencer_if.slave)
//   in : X-stage control flags/operands, hazard_stall, md_op_x, md_ready
//   out: pc, imem_addr, pc_plus1, flush_fd/flush_dx, stall_fd, stall_pipe,
//        md_start, md_timeout (flags are combinational, pc is registered)
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEF
) (
  input  logic           clock,
  input  logic           reset_n,
  pc_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             redirect_c;
  logic [PC_W-1:0]  target_c;
  logic             timeout_hit;

  next_pc_sel u_next_pc_sel (
    .pcmux_x    (bus.pcmux_x),
    .bne_x      (bus.bne_x),
    .blt_x      (bus.blt_x),
    .bex_x      (bus.bex_x),
    .neq_x      (bus.neq_x),
    .lt_x       (bus.lt_x),
    .rstatus_nz (bus.rstatus_nz),
    .pc_x       (bus.pc_x),
    .sei_x      (bus.sei_x),
    .target_x   (bus.target_x),
    .rd_val_x   (bus.rd_val_x),
    .redirect_c (redirect_c),
    .target_c   (target_c)
  );

  // Last allowed wait cycle reached
  assign timeout_hit = (cnt_q == CNT_W'(MD_TIMEOUT - 1));

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // PC and wait-counter registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  // Next state, next PC, next counter
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (redirect_c) begin
          pc_d = target_c;
        end else if (bus.md_op_x) begin
          state_d = ST_MD_WAIT;
          cnt_d   = '0;
        end else if (!bus.hazard_stall) begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      ST_MD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.md_ready || timeout_hit) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs
  always_comb begin
    bus.flush_fd   = 1'b0;
    bus.flush_dx   = 1'b0;
    bus.stall_fd   = 1'b0;
    bus.stall_pipe = 1'b0;
    bus.md_start   = 1'b0;
    bus.md_timeout = 1'b0;
    bus.pc         = pc_q;
    bus.pc_plus1   = pc_q + PC_W'(1);
    bus.imem_addr  = pc_q[IMEM_AW-1:0];
    unique case (state_q)
      ST_RUN: begin
        // A redirect squashes the stalled D instruction, so it overrides the stall.
        bus.flush_fd = redirect_c;
        bus.flush_dx = redirect_c;
        bus.stall_fd = bus.hazard_stall & ~redirect_c;
        if (bus.md_op_x && !redirect_c) begin
          bus.md_start   = 1'b1;
          bus.stall_pipe = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        // Release the pipe on ready (X/M latches the result) or on abort.
        bus.stall_pipe = ~bus.md_ready & ~timeout_hit;
        bus.md_timeout = ~bus.md_ready & timeout_hit;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: free-run, branches/jumps/bex, hazard
// freeze, multdiv handshake, timeout and reset during a multdiv wait.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_x();
    bus.pcmux_x      = 2'b00;
    bus.bne_x        = 1'b0;
    bus.blt_x        = 1'b0;
    bus.bex_x        = 1'b0;
    bus.neq_x        = 1'b0;
    bus.lt_x         = 1'b0;
    bus.rstatus_nz   = 1'b0;
    bus.pc_x         = '0;
    bus.sei_x        = '0;
    bus.target_x     = '0;
    bus.rd_val_x     = '0;
    bus.hazard_stall = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    clear_x();
    bus.md_op_x  = 1'b0;
    bus.md_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    // Reset state
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_pc_plus1", bus.pc_plus1, 32'd1);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_flush_fd", 32'(bus.flush_fd), 32'd0);
    chk("rst_flush_dx", 32'(bus.flush_dx), 32'd0);
    chk("rst_stall_fd", 32'(bus.stall_fd), 32'd0);
    chk("rst_stall_pipe", 32'(bus.stall_pipe), 32'd0);
    chk("rst_md_start", 32'(bus.md_start), 32'd0);
    chk("rst_md_timeout", 32'(bus.md_timeout), 32'd0);
    reset_n = 1'b1;

    // Free run
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("run_pc", bus.pc, 32'(i));
      chk("run_flush", 32'(bus.flush_fd), 32'd0);
    end

    // Taken bne: 10 + 1 + 5
    bus.pc_x = 32'd10; bus.sei_x = 32'd5; bus.neq_x = 1'b1; bus.bne_x = 1'b1;
    #1;
    chk("bne_flush_fd", 32'(bus.flush_fd), 32'd1);
    chk("bne_flush_dx", 32'(bus.flush_dx), 32'd1);
    tick(); clear_x();
    chk("bne_pc", bus.pc, 32'd16);

    // Not-taken blt with hazard stall
    bus.blt_x = 1'b1; bus.lt_x = 1'b0; bus.hazard_stall = 1'b1;
    #1;
    chk("haz_flush_fd", 32'(bus.flush_fd), 32'd0);
    chk("haz_stall_fd", 32'(bus.stall_fd), 32'd1);
    tick();
    chk("haz_pc1", bus.pc, 32'd16);
    tick();
    chk("haz_pc2", bus.pc, 32'd16);
    clear_x();
    tick();
    chk("haz_release_pc", bus.pc, 32'd17);

    // jr with simultaneous hazard: redirect wins
    bus.pcmux_x = PCMUX_RD; bus.rd_val_x = 32'h40; bus.hazard_stall = 1'b1;
    #1;
    chk("jr_flush_fd", 32'(bus.flush_fd), 32'd1);
    chk("jr_flush_dx", 32'(bus.flush_dx), 32'd1);
    chk("jr_stall_fd", 32'(bus.stall_fd), 32'd0);
    tick(); clear_x();
    chk("jr_pc", bus.pc, 32'h40);

    // bex taken alongside a taken bne: bex target has priority
    bus.bex_x = 1'b1; bus.rstatus_nz = 1'b1; bus.target_x = 27'h123;
    bus.bne_x = 1'b1; bus.neq_x = 1'b1;
    #1;
    chk("bex_flush", 32'(bus.flush_fd), 32'd1);
    tick(); clear_x();
    chk("bex_pc", bus.pc, 32'h123);

    // bex with r30 == 0: no redirect
    bus.bex_x = 1'b1; bus.rstatus_nz = 1'b0; bus.target_x = 27'h555;
    #1;
    chk("bex_nt_flush", 32'(bus.flush_fd), 32'd0);
    tick(); clear_x();
    chk("bex_nt_pc", bus.pc, 32'h124);

    // pcmux 01 without branch flags does not redirect
    bus.pcmux_x = PCMUX_BR; bus.sei_x = 32'd50;
    #1;
    chk("pcmux01_flush", 32'(bus.flush_fd), 32'd0);
    tick(); clear_x();
    chk("pcmux01_pc", bus.pc, 32'h125);

    // Taken blt, negative offset: 100 + 1 - 3
    bus.blt_x = 1'b1; bus.lt_x = 1'b1; bus.pc_x = 32'd100; bus.sei_x = 32'hFFFF_FFFD;
    #1;
    chk("blt_flush_dx", 32'(bus.flush_dx), 32'd1);
    tick(); clear_x();
    chk("blt_pc", bus.pc, 32'd98);

    // j to maximum target field
    bus.pcmux_x = PCMUX_TGT; bus.target_x = 27'h7FF_FFFF;
    tick(); clear_x();
    chk("j_pc", bus.pc, 32'h07FF_FFFF);
    chk("j_imem_addr", 32'(bus.imem_addr), 32'hFFF);

    // jr to all-ones then wrap
    bus.pcmux_x = PCMUX_RD; bus.rd_val_x = 32'hFFFF_FFFF;
    tick(); clear_x();
    chk("max_pc", bus.pc, 32'hFFFF_FFFF);
    chk("max_pc_plus1", bus.pc_plus1, 32'd0);
    tick();
    chk("wrap_pc", bus.pc, 32'd0);
    tick();
    chk("pre_md_pc", bus.pc, 32'd1);

    // mult: start at cycle 0, ready at cycle 5
    bus.md_op_x = 1'b1;
    #1;
    chk("mul_c0_start", 32'(bus.md_start), 32'd1);
    chk("mul_c0_stall", 32'(bus.stall_pipe), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("mul_wait_start", 32'(bus.md_start), 32'd0);
      chk("mul_wait_stall", 32'(bus.stall_pipe), 32'd1);
      chk("mul_wait_pc", bus.pc, 32'd1);
    end
    tick();
    bus.md_ready = 1'b1;
    #1;
    chk("mul_c5_stall", 32'(bus.stall_pipe), 32'd0);
    chk("mul_c5_start", 32'(bus.md_start), 32'd0);
    chk("mul_c5_timeout", 32'(bus.md_timeout), 32'd0);
    chk("mul_c5_pc", bus.pc, 32'd1);

    // Cycle 6: back in RUN, back-to-back div gets a fresh start
    tick();
    bus.md_ready = 1'b0;
    #1;
    chk("div_c0_start", 32'(bus.md_start), 32'd1);
    chk("div_c0_stall", 32'(bus.stall_pipe), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("div_wait_start", 32'(bus.md_start), 32'd0);
      if (k < 40) begin
        chk("div_wait_timeout", 32'(bus.md_timeout), 32'd0);
        chk("div_wait_stall", 32'(bus.stall_pipe), 32'd1);
      end else begin
        chk("div_timeout_pulse", 32'(bus.md_timeout), 32'd1);
        chk("div_timeout_stall", 32'(bus.stall_pipe), 32'd0);
      end
    end
    tick();
    bus.md_op_x = 1'b0;
    #1;
    chk("post_to_timeout", 32'(bus.md_timeout), 32'd0);
    chk("post_to_stall", 32'(bus.stall_pipe), 32'd0);
    bus.md_ready = 1'b1;
    #1;
    chk("run_ready_ignored", 32'(bus.stall_pipe), 32'd0);
    bus.md_ready = 1'b0;

    // div again, reset at MD_WAIT cycle 10
    bus.md_op_x = 1'b1;
    #1;
    chk("div2_start", 32'(bus.md_start), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("div2_wait_stall", 32'(bus.stall_pipe), 32'd1);
    end
    tick();
    reset_n = 1'b0;
    bus.md_op_x = 1'b0;
    tick();
    chk("div2_rst_pc", bus.pc, 32'd0);
    chk("div2_rst_stall", 32'(bus.stall_pipe), 32'd0);
    chk("div2_rst_timeout", 32'(bus.md_timeout), 32'd0);
    reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("div2_no_timeout", 32'(bus.md_timeout), 32'd0);
      chk("div2_no_stall", 32'(bus.stall_pipe), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and fetch-redirect unit for the five-stage pipeline. Owns the PC register and the next-PC selection from the execute-stage control flags: jumps, taken branches, jr, bex. Also generates F/D and D/X flushes, freezes fetch on hazard stalls, and runs the start/ready handshake with the multdiv unit while a mult/div sits in execute.

## Interface
- PC_W, 32, PC and operand width
- IMEM_AW, 12, instruction-memory address width; imem_addr = pc[IMEM_AW-1:0]
- MD_TIMEOUT, 40, max MD_WAIT cycles before abort
- clock  in  1  single clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- pcmux_x  in  2  PC select from control for the X-stage instruction: 00 PC+1, 01 branch, 10 target (j/jal), 11 rd value (jr)
- bne_x, blt_x, bex_x  in  1 each  X-stage branch-type flags
- neq_x, lt_x  in  1 each  ALU compare results for the X-stage operands
- rstatus_nz  in  1  r30 != 0, forwarded
- pc_x  in  PC_W  PC of the X-stage instruction
- sei_x  in  PC_W  sign-extended immediate
- target_x  in  27  jump target field
- rd_val_x  in  PC_W  forwarded $rd value for jr
- hazard_stall  in  1  load-use stall request from D
- md_op_x  in  1  X-stage instruction is mult or div
- md_ready  in  1  multdiv result valid, one-cycle pulse
- pc  out  PC_W  current fetch PC
- imem_addr  out  IMEM_AW  fetch address
- pc_plus1  out  PC_W  pc + 1, for F/D latch
- flush_fd, flush_dx  out  1 each  load NOP into F/D, D/X at next edge
- stall_fd  out  1  hold F/D
- stall_pipe  out  1  hold F/D, D/X, X/M; bubble into M/W
- md_start  out  1  one-cycle start pulse to multdiv
- md_timeout  out  1  one-cycle abort pulse

## Operation
- States: RUN, MD_WAIT. Reset: state RUN, pc 0, cycle counter 0. All outputs 0 except pc_plus1 = 1 and imem_addr = 0.
- Redirect is computed in RUN only.
  - br_taken = (bne_x & neq_x) | (blt_x & lt_x).
  - bex_taken = bex_x & rstatus_nz.
  - Redirect = br_taken | bex_taken | pcmux_x[1].
  - pcmux_x[0] is not used for branch decision; bne/blt flags are authoritative.
- Next PC, in priority order:
  1. bex_taken or pcmux_x==10: {5'b0, target_x}.
  2. pcmux_x==11: rd_val_x.
  3. br_taken: pc_x + 1 + sei_x, mod 2^PC_W.
  4. Otherwise, if no stall, pc + 1.
- Redirect asserts flush_fd and flush_dx in the same cycle.
- Redirect beats hazard_stall: the stalled D instruction is squashed, and the PC loads the target.
- hazard_stall alone holds pc and asserts stall_fd. The D/X NOP is inserted by the hazard unit, not here.
- RUN & md_op_x & !redirect:
  - Assert md_start this cycle.
  - Assert stall_pipe this cycle.
  - Go to MD_WAIT and clear the counter.
- MD_WAIT:
  - stall_pipe = !md_ready; pc held; counter increments.
  - md_ready: stall_pipe deasserts that cycle so X/M latches the result. Next state RUN.
  - Counter reaches MD_TIMEOUT - 1 without ready: pulse md_timeout, deassert stall_pipe, go to RUN. Exception write to r30 is handled downstream.
- Back-to-back mult/div: next md_op_x in RUN issues a fresh md_start.
- PC wraps 0xFFFFFFFF -> 0. imem_addr truncates.

## Timing
- Combinational flags to flush/stall/md_start; PC updates at the next edge. Redirect penalty is two squashed instructions.
- md_start is exactly one cycle per mult/div, never in MD_WAIT.
- md_ready in RUN is ignored.
- reset_n low mid-MD_WAIT: RUN at the next edge, pc 0, no md_timeout pulse.

## Structure
- Shared cpu_pkg holds:
  - PCMUX_* encodings (00/01/10/11).
  - State encoding.
  - RSTATUS_REG = 30 and RA_REG = 31.
- One sub-module, next_pc_sel: combinational redirect and target mux. FSM, counter and PC register stay in the top.

## Test plan
- Reset, then 3 free-running cycles -> pc = 0, 1, 2, 3; no flush.
- Taken bne: pc_x = 10, sei_x = 5, neq_x = 1, bne_x = 1 -> flush_fd = flush_dx = 1 that cycle; pc = 16 next.
- blt_x = 1, lt_x = 0, with hazard_stall = 1 -> pc held 2 cycles, stall_fd = 1, no flush.
- jr with rd_val_x = 0x40 plus simultaneous hazard_stall -> pc = 0x40; flush wins.
- mult in X, md_ready at cycle 5 -> md_start 1 cycle; stall_pipe cycles 0–4; RUN at cycle 6; pc frozen throughout.
- div with no ready, MD_TIMEOUT = 40 -> md_timeout pulses on the 40th MD_WAIT cycle; state RUN.
- Same test repeated with reset_n low at cycle 10 -> no timeout pulse, pc = 0.
